// File: rtl/fcmp_pkg.sv
// ============================================================================
// Module : fcmp_pkg
// Brief  : Shared FloPoCo 8/23 float types, exception codes and slot states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fcmp_pkg;

    localparam int FP_W = 34;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef struct packed {
        logic [1:0]  exc;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp34_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Unsigned magnitude key; zero and infinity ignore exp/frac so that all
    // zeros and all same-signed infinities compare equal.
    function automatic logic [32:0] fp_mag_key(input fp34_t v);
        logic [32:0] key;
        key = '0;
        case (v.exc)
            EXC_NORMAL: key = {EXC_NORMAL, v.exp, v.frac};
            EXC_INF:    key = {EXC_INF, 31'd0};
            default:    key = '0;
        endcase
        return key;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fcmplt.sv
// ============================================================================
// Module : fcmplt
// Brief  : Combinational FloPoCo 8/23 float less-than with unordered flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fcmplt
    import fcmp_pkg::*;
#(
    parameter int ID = 0
) (
    input  logic [FP_W-1:0] i_x,
    input  logic [FP_W-1:0] i_y,
    output logic            o_xlty,
    output logic            o_unordered
);

    fp34_t       w_x;
    fp34_t       w_y;
    logic [32:0] w_key_x;
    logic [32:0] w_key_y;
    logic        w_both_zero;

    // Instance id only tags the instance; a negative value is never legal.
    if (ID < 0) begin : g_id_guard
    end

    assign w_x         = fp34_t'(i_x);
    assign w_y         = fp34_t'(i_y);
    assign w_key_x     = fp_mag_key(w_x);
    assign w_key_y     = fp_mag_key(w_y);
    assign w_both_zero = (w_x.exc == EXC_ZERO) && (w_y.exc == EXC_ZERO);
    assign o_unordered = (w_x.exc == EXC_NAN) || (w_y.exc == EXC_NAN);

    always_comb begin
        o_xlty = 1'b0;
        if (!o_unordered && !w_both_zero) begin
            if (w_x.sign != w_y.sign) begin
                o_xlty = w_x.sign;
            end else if (w_x.sign) begin
                o_xlty = (w_key_x > w_key_y);
            end else begin
                o_xlty = (w_key_x < w_key_y);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fcmplt_rr_arbiter_pick.sv
// ============================================================================
// Module : fcmplt_rr_pick
// Brief  : Combinational round-robin picker: first valid at or above ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fcmplt_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin : p_pick
        logic [IDW-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_valid[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fcmplt_rr_arbiter.sv
// ============================================================================
// Module : fcmplt_rr_arbiter
// Brief  : Round-robin sharing of one fcmplt among NREQ requesters with a
//          single registered, id-tagged response slot.
//          Optional statistics counters under FCMPLT_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fcmplt_rr_arbiter
    import fcmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WE   = 8,
    parameter int WF   = 23
`ifdef FCMPLT_ARB_STATS_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*(WE+WF+3)-1:0]    req_x,
    input  logic [NREQ*(WE+WF+3)-1:0]    req_y,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic                         rsp_xlty,
    output logic                         rsp_unordered
`ifdef FCMPLT_ARB_STATS_EN
    ,
    output logic [NREQ*CNTW-1:0]         grant_cnt,
    output logic [CNTW-1:0]              unord_cnt
`endif
);

    localparam int c_fp_w = WE + WF + 3;
    localparam int c_idw  = $clog2(NREQ);

    slot_state_t        r_state;
    slot_state_t        w_state_nxt;
    logic               r_run;
    logic [c_idw-1:0]   r_ptr;
    logic [c_idw-1:0]   w_idx;
    logic [NREQ-1:0]    w_grant;
    logic               w_any;
    logic               w_accept;
    logic               w_xfer;
    logic [c_fp_w-1:0]  w_x;
    logic [c_fp_w-1:0]  w_y;
    logic               w_lt;
    logic               w_un;

    fcmplt_rr_pick #(
        .NREQ (NREQ),
        .IDW  (c_idw)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept  = r_run && ((r_state == SLOT_EMPTY) || rsp_ready);
    assign w_xfer    = w_accept && w_any;
    assign req_ready = {NREQ{w_accept}} & w_grant;
    assign rsp_valid = (r_state == SLOT_FULL);

    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_x = req_x[i*c_fp_w +: c_fp_w];
                w_y = req_y[i*c_fp_w +: c_fp_w];
            end
        end
    end

    fcmplt #(
        .ID (1)
    ) u_fcmplt (
        .i_x         (w_x),
        .i_y         (w_y),
        .o_xlty      (w_lt),
        .o_unordered (w_un)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // A transfer in the same cycle as a pop overwrites the slot, keeping it FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_xfer) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !w_xfer) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id        <= '0;
            rsp_xlty      <= 1'b0;
            rsp_unordered <= 1'b0;
            r_ptr         <= '0;
        end else if (w_xfer) begin
            rsp_id        <= w_idx;
            rsp_xlty      <= w_lt;
            rsp_unordered <= w_un;
            r_ptr         <= (w_idx == c_idw'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

`ifdef FCMPLT_ARB_STATS_EN
    logic [CNTW-1:0] r_unord_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_grant_cnt
        logic [CNTW-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (req_ready[g] && req_valid[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign grant_cnt[g*CNTW +: CNTW] = r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unord_cnt <= '0;
        end else if (w_xfer && w_un && (r_unord_cnt != '1)) begin
            r_unord_cnt <= r_unord_cnt + 1'b1;
        end
    end

    assign unord_cnt = r_unord_cnt;
`endif

endmodule

`default_nettype wire
